divider_scheduler: RTL and testbench

Shares one iterative unsigned divider among `NUM_REQ` requesters, for example the per-vertex coordinate-normalisation divisions in the card-projection pipeline. The block arbitrates requests round-robin and runs one radix-2 restoring division at a time. It returns each result tagged with the requester index. It replaces a bank of parallel dividers with a single time-multiplexed unit when area matters more than throughput.

---
 rtl/divider_scheduler.sv | 143 ++++++++++++++
 tb/tb_divider_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : divider_scheduler
// Brief    : Round-robin shared radix-2 restoring unsigned divider.
// Revision : 1.0
// ============================================================================

module divider_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 9
) (
  input  logic                       clk_in,
  input  logic                       rst_in_n,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  input  logic [WIDTH-1:0]           dividend_in [NUM_REQ],
  input  logic [WIDTH-1:0]           divisor_in  [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready_out,
  output logic                       resp_valid_out,
  output logic [$clog2(NUM_REQ)-1:0] resp_id_out,
  output logic [WIDTH-1:0]           quotient_out,
  output logic [WIDTH-1:0]           remainder_out,
  output logic                       div_by_zero_out,
  output logic                       busy_out
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = $clog2(WIDTH);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_div  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]         r_state;
  logic [c_id_w-1:0]  r_last;
  logic [c_id_w-1:0]  r_id;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-2:0]   r_quot;
  logic [c_cnt_w-1:0] r_count;

  logic [c_id_w-1:0]  w_grant_id;
  logic [c_id_w-1:0]  w_idx;
  logic               w_grant_found;
  logic               w_accept;
  logic [WIDTH:0]     w_rem_shift;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quot_next;

  // Scan from farthest to nearest so the requester right after r_last wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_id    = '0;
    w_idx         = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = c_id_w'((int'(r_last) + k) % NUM_REQ);
      if (req_valid_in[w_idx]) begin
        w_grant_found = 1'b1;
        w_grant_id    = w_idx;
      end
    end
  end

  assign w_accept = w_grant_found && (r_state != c_st_div);

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
      assign req_ready_out[g] = rst_in_n && w_accept && (w_grant_id == c_id_w'(g));
    end
  endgenerate

  // One restoring step; the shifted partial remainder needs one extra bit.
  assign w_rem_shift = {r_rem, r_dividend[WIDTH-1]};
  assign w_qbit      = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - r_divisor;
  assign w_rem_next  = w_qbit ? w_rem_sub : w_rem_shift[WIDTH-1:0];
  assign w_quot_next = {r_quot, w_qbit};

  assign resp_valid_out = (r_state == c_st_done);
  assign busy_out       = (r_state == c_st_div);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state         <= c_st_idle;
      r_last          <= c_id_w'(NUM_REQ - 1);
      r_id            <= '0;
      r_dividend      <= '0;
      r_divisor       <= '0;
      r_rem           <= '0;
      r_quot          <= '0;
      r_count         <= '0;
      resp_id_out     <= '0;
      quotient_out    <= '0;
      remainder_out   <= '0;
      div_by_zero_out <= 1'b0;
    end else begin
      case (r_state)
        c_st_div: begin
          r_rem      <= w_rem_next;
          r_quot     <= w_quot_next[WIDTH-2:0];
          r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
          if (r_count == '0) begin
            r_state         <= c_st_done;
            quotient_out    <= w_quot_next;
            remainder_out   <= w_rem_next;
            div_by_zero_out <= 1'b0;
            resp_id_out     <= r_id;
          end else begin
            r_count <= r_count - c_cnt_w'(1);
          end
        end
        default: begin
          if (w_accept) begin
            r_last <= w_grant_id;
            r_id   <= w_grant_id;
            if (divisor_in[w_grant_id] == '0) begin
              // Zero divisor bypasses the iteration entirely.
              r_state         <= c_st_done;
              quotient_out    <= '1;
              remainder_out   <= dividend_in[w_grant_id];
              div_by_zero_out <= 1'b1;
              resp_id_out     <= w_grant_id;
            end else begin
              r_state    <= c_st_div;
              r_rem      <= '0;
              r_quot     <= '0;
              r_dividend <= dividend_in[w_grant_id];
              r_divisor  <= divisor_in[w_grant_id];
              r_count    <= c_cnt_w'(WIDTH - 1);
            end
          end else begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_scheduler
// Brief    : Directed plus random stimulus against a job-level divider model.
// Revision : 1.0
// ============================================================================

module tb_divider_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 9;

  logic               clk_in   = 1'b0;
  logic               rst_in_n = 1'b0;
  logic [NUM_REQ-1:0] req_valid;
  logic [WIDTH-1:0]   dividend [NUM_REQ];
  logic [WIDTH-1:0]   divisor  [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready_out;
  logic               resp_valid_out;
  logic [1:0]         resp_id_out;
  logic [WIDTH-1:0]   quotient_out;
  logic [WIDTH-1:0]   remainder_out;
  logic               div_by_zero_out;
  logic               busy_out;

  always #5 clk_in = ~clk_in;

  divider_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk_in          (clk_in),
    .rst_in_n        (rst_in_n),
    .req_valid_in    (req_valid),
    .dividend_in     (dividend),
    .divisor_in      (divisor),
    .req_ready_out   (req_ready_out),
    .resp_valid_out  (resp_valid_out),
    .resp_id_out     (resp_id_out),
    .quotient_out    (quotient_out),
    .remainder_out   (remainder_out),
    .div_by_zero_out (div_by_zero_out),
    .busy_out        (busy_out)
  );

  typedef struct {int a; int b;} job_t;
  typedef struct {int cyc; int id; int q; int r; int dbz;} ev_t;

  job_t jq [NUM_REQ][$];
  ev_t  hs_log[$];
  ev_t  resp_log[$];

  int checks = 0, errors = 0, cyc = 0, busy_cycles = 0, ready_cycles = 0;
  logic [NUM_REQ-1:0] last_hs = '0;

  // Job-level model: a job in flight is just a countdown to its response.
  int m_last, m_left, m_resp, m_id, m_q, m_r, m_dbz, p_id, p_q, p_r;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [NUM_REQ-1:0] v, int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int j = (last + k) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NUM_REQ - 1; m_left = 0; m_resp = 0;
    m_id = 0; m_q = 0; m_r = 0; m_dbz = 0;
    last_hs = '0;
  endtask

  initial begin : compare
    int pick, exp_rdy, a, b;
    model_reset();
    forever begin
      @(negedge clk_in); #1;
      if (!rst_in_n) begin
        model_reset();
        chk("rst_ready", int'(req_ready_out), 0);
        chk("rst_resp_valid", int'(resp_valid_out), 0);
        chk("rst_busy", int'(busy_out), 0);
        chk("rst_id", int'(resp_id_out), 0);
        chk("rst_quotient", int'(quotient_out), 0);
        chk("rst_remainder", int'(remainder_out), 0);
        chk("rst_dbz", int'(div_by_zero_out), 0);
      end else begin
        pick    = rr_pick(req_valid, m_last);
        exp_rdy = (m_left == 0 && pick >= 0) ? (1 << pick) : 0;
        chk("ready", int'(req_ready_out), exp_rdy);
        if (req_ready_out != '0) ready_cycles++;
      end
      @(posedge clk_in);
      cyc++;
      last_hs = '0;
      if (rst_in_n) begin
        m_resp = 0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_resp = 1; m_id = p_id; m_q = p_q; m_r = p_r; m_dbz = 0;
          end
        end else begin
          pick = rr_pick(req_valid, m_last);
          if (pick >= 0) begin
            a = int'(dividend[pick]);
            b = int'(divisor[pick]);
            last_hs[pick] = 1'b1;
            m_last = pick;
            hs_log.push_back('{cyc, pick, a, b, 0});
            if (b == 0) begin
              m_resp = 1; m_id = pick; m_q = (1 << WIDTH) - 1; m_r = a; m_dbz = 1;
            end else begin
              m_left = WIDTH; p_id = pick; p_q = a / b; p_r = a % b;
            end
          end
        end
      end else begin
        model_reset();
      end
      #1;
      if (rst_in_n) begin
        chk("resp_valid", int'(resp_valid_out), m_resp);
        chk("busy", int'(busy_out), (m_left > 0) ? 1 : 0);
        chk("resp_id", int'(resp_id_out), m_id);
        chk("quotient", int'(quotient_out), m_q);
        chk("remainder", int'(remainder_out), m_r);
        chk("dbz", int'(div_by_zero_out), m_dbz);
        if (busy_out) busy_cycles++;
        if (resp_valid_out)
          resp_log.push_back('{cyc, int'(resp_id_out), int'(quotient_out),
                               int'(remainder_out), int'(div_by_zero_out)});
      end
    end
  end

  // Each requester presents the head of its queue until granted.
  initial begin : driver
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dividend[i] = '0;
      divisor[i]  = '0;
    end
    forever begin
      @(negedge clk_in);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_hs[i] && jq[i].size() > 0) void'(jq[i].pop_front());
        if (jq[i].size() > 0) begin
          req_valid[i] = 1'b1;
          dividend[i]  = WIDTH'(jq[i][0].a);
          divisor[i]   = WIDTH'(jq[i][0].b);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic push(int i, int a, int b);
    jq[i].push_back('{a, b});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  function automatic bit is_idle();
    for (int i = 0; i < NUM_REQ; i++) if (jq[i].size() != 0) return 1'b0;
    return (req_valid == '0) && (m_left == 0) && (m_resp == 0);
  endfunction

  task automatic wait_idle(int budget);
    int n = 0;
    do begin tick(1); n++; end while (!is_idle() && n < budget);
    if (!is_idle()) begin
      checks++; errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic wait_hs(int h_before, int budget);
    int n = 0;
    do begin tick(1); n++; end while (hs_log.size() <= h_before && n < budget);
    if (hs_log.size() <= h_before) begin
      checks++; errors++;
      $display("FAIL grant_timeout: no grant within %0d cycles", budget);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int h0, r0, b0, y0, h1, cnt;
    int sa[4] = '{400, 255, 8, 300};
    int sb[4] = '{3, 16, 9, 300};
    int eq[4] = '{133, 15, 0, 1};
    int er[4] = '{1, 15, 8, 0};

    tick(3);
    rst_in_n = 1'b1;
    tick(2);

    chk("model_rr_a", rr_pick(4'b1010, 3), 1);
    chk("model_rr_b", rr_pick(4'b1010, 1), 3);
    chk("model_rr_c", rr_pick(4'b0001, 0), 0);

    // All four at once, fresh pointer.
    h0 = hs_log.size(); r0 = resp_log.size();
    for (int i = 0; i < 4; i++) push(i, sa[i], sb[i]);
    wait_idle(120);
    chk("sim_hs_cnt", hs_log.size() - h0, 4);
    chk("sim_resp_cnt", resp_log.size() - r0, 4);
    if (hs_log.size() - h0 == 4 && resp_log.size() - r0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("sim_grant_order", hs_log[h0+k].id, k);
        chk("sim_resp_id", resp_log[r0+k].id, k);
        chk("sim_q", resp_log[r0+k].q, eq[k]);
        chk("sim_r", resp_log[r0+k].r, er[k]);
        if (k > 0) chk("sim_spacing", resp_log[r0+k].cyc - resp_log[r0+k-1].cyc, 10);
      end
    end
    h0 = hs_log.size();
    for (int i = 0; i < 4; i++) push(i, sa[i], sb[i]);
    wait_idle(120);
    if (hs_log.size() > h0) chk("sim_round2_first", hs_log[h0].id, 0);

    // Single job.
    h0 = hs_log.size(); r0 = resp_log.size(); b0 = busy_cycles; y0 = ready_cycles;
    push(0, 100, 7);
    wait_idle(60);
    chk("single_resp_cnt", resp_log.size() - r0, 1);
    if (resp_log.size() > r0 && hs_log.size() > h0) begin
      chk("single_id", resp_log[r0].id, 0);
      chk("single_q", resp_log[r0].q, 14);
      chk("single_r", resp_log[r0].r, 2);
      chk("single_dbz", resp_log[r0].dbz, 0);
      chk("single_latency", resp_log[r0].cyc - hs_log[h0].cyc, 9);
    end
    chk("single_busy_cycles", busy_cycles - b0, 9);
    chk("single_ready_cycles", ready_cycles - y0, 1);

    // Divide by zero, then the pointer must sit at 2.
    h0 = hs_log.size(); r0 = resp_log.size();
    push(2, 55, 0);
    wait_idle(20);
    if (resp_log.size() > r0 && hs_log.size() > h0) begin
      chk("dbz_id", resp_log[r0].id, 2);
      chk("dbz_q", resp_log[r0].q, 511);
      chk("dbz_r", resp_log[r0].r, 55);
      chk("dbz_flag", resp_log[r0].dbz, 1);
      chk("dbz_latency", resp_log[r0].cyc - hs_log[h0].cyc, 0);
    end else chk("dbz_resp_cnt", resp_log.size() - r0, 1);
    h0 = hs_log.size();
    push(0, 1, 1); push(3, 2, 1);
    wait_idle(60);
    if (hs_log.size() - h0 == 2) begin
      chk("dbz_ptr_next", hs_log[h0].id, 3);
      chk("dbz_ptr_after", hs_log[h0+1].id, 0);
    end else chk("dbz_ptr_hs_cnt", hs_log.size() - h0, 2);

    // Fairness with 1 and 3 continuously valid.
    h0 = hs_log.size(); r0 = resp_log.size();
    for (int k = 0; k < 4; k++) begin push(1, 511, 1); push(3, 511, 1); end
    wait_idle(200);
    chk("fair_resp_cnt", resp_log.size() - r0, 8);
    if (hs_log.size() - h0 == 8 && resp_log.size() - r0 == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("fair_grant", hs_log[h0+k].id, (k % 2 == 0) ? 1 : 3);
        chk("fair_q", resp_log[r0+k].q, 511);
        chk("fair_r", resp_log[r0+k].r, 0);
        if (k > 0) chk("fair_gap", hs_log[h0+k].cyc - hs_log[h0+k-1].cyc, 10);
      end
    end

    // Reset mid-division.
    h0 = hs_log.size();
    push(1, 200, 3);
    wait_hs(h0, 20);
    tick(4);
    rst_in_n = 1'b0;
    r0 = resp_log.size();
    push(1, 10, 2); push(2, 20, 4);
    tick(3);
    rst_in_n = 1'b1;
    h1 = hs_log.size();
    wait_idle(100);
    chk("rst_resp_cnt", resp_log.size() - r0, 2);
    cnt = 0;
    for (int k = r0; k < resp_log.size(); k++) if (resp_log[k].q == 66) cnt++;
    chk("rst_discarded", cnt, 0);
    if (hs_log.size() > h1) chk("rst_first_grant", hs_log[h1].id, 1);
    if (resp_log.size() - r0 == 2) begin
      chk("rst_resp0_id", resp_log[r0].id, 1);
      chk("rst_resp0_q", resp_log[r0].q, 5);
      chk("rst_resp1_id", resp_log[r0+1].id, 2);
    end

    // Withdrawal of requester 2 during DIV.
    h0 = hs_log.size();
    push(0, 300, 7);
    wait_hs(h0, 20);
    r0 = resp_log.size();
    push(2, 77, 5); push(3, 66, 6);
    tick(3);
    jq[2].delete();
    wait_idle(100);
    chk("wd_hs_cnt", hs_log.size() - h0, 2);
    if (hs_log.size() - h0 == 2) chk("wd_grant", hs_log[h0+1].id, 3);
    cnt = 0;
    for (int k = r0; k < resp_log.size(); k++) if (resp_log[k].id == 2) cnt++;
    chk("wd_no_id2", cnt, 0);
    if (resp_log.size() > r0) begin
      chk("wd_q0", resp_log[r0].q, 42);
      chk("wd_r0", resp_log[r0].r, 6);
    end

    // Random traffic with occasional withdrawals.
    for (int n = 0; n < 2000; n++) begin
      int i, a, b, sel;
      tick(1);
      if ($urandom_range(0, 3) == 0) begin
        i   = int'($urandom_range(0, NUM_REQ - 1));
        a   = int'($urandom_range(0, 511));
        sel = int'($urandom_range(0, 7));
        b   = (sel == 0) ? 0 : (sel < 3) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 511));
        if (jq[i].size() < 3) push(i, a, b);
      end
      if ($urandom_range(0, 59) == 0) begin
        i = int'($urandom_range(0, NUM_REQ - 1));
        if (!last_hs[i]) jq[i].delete();
      end
    end
    wait_idle(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
